// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 side bundle of the exception arbiter.
// master drives MEM and CP0 state; slave is the arbiter.
interface exc_ctrl_if;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i;
  logic [31:0] epc_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_delayslot_i;
  logic [31:0] mem_badaddr_i;
  logic        mem_syscall_i;
  logic        mem_break_i;
  logic        mem_ov_i;
  logic        mem_adel_i;
  logic        mem_ades_i;
  logic        mem_eret_i;
  logic        exc_int_o;
  logic        exc_syscall_o;
  logic        exc_break_o;
  logic        exc_ov_o;
  logic        exc_adel_o;
  logic        exc_ades_o;
  logic        eret_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] exc_badaddr_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output int_i, timer_int_i, status_i, epc_i,
    output mem_valid_i, mem_pc_i, mem_delayslot_i,
    output mem_badaddr_i, mem_syscall_i, mem_break_i,
    output mem_ov_i, mem_adel_i, mem_ades_i, mem_eret_i,
    input  exc_int_o, exc_syscall_o, exc_break_o,
    input  exc_ov_o, exc_adel_o, exc_ades_o, eret_o,
    input  exc_pc_o, exc_delayslot_o, exc_badaddr_o,
    input  flush_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  int_i, timer_int_i, status_i, epc_i,
    input  mem_valid_i, mem_pc_i, mem_delayslot_i,
    input  mem_badaddr_i, mem_syscall_i, mem_break_i,
    input  mem_ov_i, mem_adel_i, mem_ades_i, mem_eret_i,
    output exc_int_o, exc_syscall_o, exc_break_o,
    output exc_ov_o, exc_adel_o, exc_ades_o, eret_o,
    output exc_pc_o, exc_delayslot_o, exc_badaddr_o,
    output flush_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter between MEM and CP0.
// Picks one event by priority, pulses CP0, flushes, then redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIR
  } state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // one-hot {int, adel, ades, ov, sys, bp, eret}
  logic [6:0]  pulse_q, pulse_d;
  logic        flush_q, flush_d;
  logic        redir_q, redir_d;
  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] tgt_q, tgt_d;

  logic [5:0] sync;
  logic [5:0] ip;
  logic       int_take;
  logic [6:0] sel;

  always_comb begin
    sync_d[0] = bus.int_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync = sync_q[SYNC_STAGES-1];
    ip = {bus.timer_int_i | sync[5], sync[4:0]};
    int_take = bus.status_i[0] & ~bus.status_i[1]
             & (|(ip & bus.status_i[15:10]))
             & bus.mem_valid_i;
  end

  always_comb begin
    sel = '0;
    if (int_take) begin
      sel[6] = 1'b1;
    end else if (bus.mem_valid_i) begin
      if (bus.mem_adel_i)         sel[5] = 1'b1;
      else if (bus.mem_ades_i)    sel[4] = 1'b1;
      else if (bus.mem_ov_i)      sel[3] = 1'b1;
      else if (bus.mem_syscall_i) sel[2] = 1'b1;
      else if (bus.mem_break_i)   sel[1] = 1'b1;
      else if (bus.mem_eret_i)    sel[0] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    flush_d = 1'b0;
    redir_d = 1'b0;
    pc_d    = pc_q;
    ds_d    = ds_q;
    bad_d   = bad_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (|sel) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
          pulse_d = sel;
          flush_d = 1'b1;
          pc_d    = bus.mem_pc_i;
          ds_d    = bus.mem_delayslot_i;
          bad_d   = bus.mem_badaddr_i;
          // sel[0] can only win when nothing else is pending
          tgt_d   = sel[0] ? bus.epc_i : EXC_VECTOR;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = REDIR;
          redir_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          flush_d = 1'b1;
        end
      end
      REDIR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      pc_q    <= '0;
      ds_q    <= 1'b0;
      bad_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      pc_q    <= pc_d;
      ds_q    <= ds_d;
      bad_q   <= bad_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.exc_int_o       = pulse_q[6];
  assign bus.exc_adel_o      = pulse_q[5];
  assign bus.exc_ades_o      = pulse_q[4];
  assign bus.exc_ov_o        = pulse_q[3];
  assign bus.exc_syscall_o   = pulse_q[2];
  assign bus.exc_break_o     = pulse_q[1];
  assign bus.eret_o          = pulse_q[0];
  assign bus.exc_pc_o        = pc_q;
  assign bus.exc_delayslot_o = ds_q;
  assign bus.exc_badaddr_o   = bad_q;
  assign bus.flush_o         = flush_q;
  assign bus.redirect_o      = redir_q;
  assign bus.redirect_pc_o   = tgt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Random + directed bench for exc_ctrl against an event-timeline model.
// Each accepted event at cycle N fixes the whole following window.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int FC = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exc_ctrl_if bus ();

  exc_ctrl #(
    .EXC_VECTOR  (VEC),
    .FLUSH_CYCLES(FC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int ev = -100;
  logic [5:0]  pipe [SS];
  logic [6:0]  p_code;
  logic [31:0] p_pc, p_bad, p_tgt;
  logic        p_ds;
  logic [31:0] h_pc, h_bad, h_tgt;
  logic        h_ds;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.int_i = '0;
    bus.timer_int_i = 1'b0;
    bus.status_i = '0;
    bus.epc_i = '0;
    bus.mem_valid_i = 1'b0;
    bus.mem_pc_i = '0;
    bus.mem_delayslot_i = 1'b0;
    bus.mem_badaddr_i = '0;
    bus.mem_syscall_i = 1'b0;
    bus.mem_break_i = 1'b0;
    bus.mem_ov_i = 1'b0;
    bus.mem_adel_i = 1'b0;
    bus.mem_ades_i = 1'b0;
    bus.mem_eret_i = 1'b0;
  endtask

  task automatic model_clear();
    ev = -100;
    h_pc = '0; h_bad = '0; h_tgt = '0; h_ds = 1'b0;
    for (int i = 0; i < SS; i++) pipe[i] = '0;
  endtask

  // Decide from the current inputs what the arbiter accepts this cycle.
  task automatic model_eval();
    logic [5:0] s, ip;
    logic it;
    logic [6:0] code;
    s = pipe[SS-1];
    for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = bus.int_i;
    if (cyc >= ev + FC + 2 && bus.mem_valid_i) begin
      ip = {bus.timer_int_i | s[5], s[4:0]};
      it = bus.status_i[0] && !bus.status_i[1]
           && ((ip & bus.status_i[15:10]) != 0);
      code = '0;
      if (it) code = 7'b1000000;
      else if (bus.mem_adel_i) code = 7'b0100000;
      else if (bus.mem_ades_i) code = 7'b0010000;
      else if (bus.mem_ov_i) code = 7'b0001000;
      else if (bus.mem_syscall_i) code = 7'b0000100;
      else if (bus.mem_break_i) code = 7'b0000010;
      else if (bus.mem_eret_i) code = 7'b0000001;
      if (code != 0) begin
        ev = cyc;
        p_code = code;
        p_pc = bus.mem_pc_i;
        p_ds = bus.mem_delayslot_i;
        p_bad = bus.mem_badaddr_i;
        p_tgt = (code == 7'b0000001) ? bus.epc_i : VEC;
      end
    end
  endtask

  task automatic check_cycle();
    logic [6:0] obs, exp;
    logic ef, er;
    if (cyc == ev + 1) begin
      h_pc = p_pc; h_ds = p_ds; h_bad = p_bad; h_tgt = p_tgt;
    end
    exp = (cyc == ev + 1) ? p_code : 7'b0;
    ef = (cyc >= ev + 1) && (cyc <= ev + FC);
    er = (cyc == ev + FC + 1);
    obs = {bus.exc_int_o, bus.exc_adel_o, bus.exc_ades_o, bus.exc_ov_o,
           bus.exc_syscall_o, bus.exc_break_o, bus.eret_o};
    chk("pulse", 32'(obs), 32'(exp));
    chk("flush", 32'(bus.flush_o), 32'(ef));
    chk("redirect", 32'(bus.redirect_o), 32'(er));
    chk("exc_pc", bus.exc_pc_o, h_pc);
    chk("exc_ds", 32'(bus.exc_delayslot_o), 32'(h_ds));
    chk("exc_bad", bus.exc_badaddr_o, h_bad);
    chk("redir_pc", bus.redirect_pc_o, h_tgt);
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_in();
    bus.mem_valid_i = ($urandom_range(3) != 0);
    bus.mem_pc_i = $urandom;
    bus.mem_delayslot_i = 1'($urandom);
    bus.mem_badaddr_i = $urandom;
    bus.epc_i = $urandom;
    bus.mem_syscall_i = ($urandom_range(9) == 0);
    bus.mem_break_i = ($urandom_range(9) == 0);
    bus.mem_ov_i = ($urandom_range(9) == 0);
    bus.mem_adel_i = ($urandom_range(9) == 0);
    bus.mem_ades_i = ($urandom_range(9) == 0);
    bus.mem_eret_i = ($urandom_range(9) == 0);
    bus.timer_int_i = ($urandom_range(15) == 0);
    if ($urandom_range(7) == 0) bus.int_i = 6'($urandom);
    bus.status_i = {16'h0, 8'($urandom), 6'h0,
                    ($urandom_range(3) == 0), 1'($urandom)};
  endtask

  initial begin
    idle_in();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle();
    rst = 1'b1;
    steps(3);

    // syscall commit and vector redirect
    bus.mem_valid_i = 1'b1;
    bus.mem_syscall_i = 1'b1;
    bus.mem_pc_i = 32'h80000010;
    step();
    idle_in();
    steps(5);

    // eret to EPC
    bus.mem_valid_i = 1'b1;
    bus.mem_eret_i = 1'b1;
    bus.epc_i = 32'h80001234;
    step();
    idle_in();
    steps(5);

    // interrupt beats overflow once synchronized
    bus.int_i = 6'h01;
    bus.status_i = 32'h0000_0401;
    steps(3);
    bus.mem_valid_i = 1'b1;
    bus.mem_ov_i = 1'b1;
    step();
    bus.mem_valid_i = 1'b0;
    bus.mem_ov_i = 1'b0;
    steps(5);
    // EXL masks the interrupt
    bus.status_i = 32'h0000_0403;
    bus.mem_valid_i = 1'b1;
    steps(3);
    idle_in();
    steps(3);

    // adel over ades, bad address committed
    bus.mem_valid_i = 1'b1;
    bus.mem_adel_i = 1'b1;
    bus.mem_ades_i = 1'b1;
    bus.mem_badaddr_i = 32'h3;
    step();
    // break during flush is dropped
    bus.mem_adel_i = 1'b0;
    bus.mem_ades_i = 1'b0;
    bus.mem_break_i = 1'b1;
    steps(2);
    idle_in();
    steps(3);

    // bubble with flags set
    bus.mem_syscall_i = 1'b1;
    bus.mem_ov_i = 1'b1;
    steps(3);
    idle_in();
    steps(2);

    // reset in the middle of a flush
    bus.mem_valid_i = 1'b1;
    bus.mem_break_i = 1'b1;
    step();
    idle_in();
    #1 rst = 1'b0;
    #1;
    chk("rst_flush", 32'(bus.flush_o), 32'h0);
    chk("rst_brk", 32'(bus.exc_break_o), 32'h0);
    chk("rst_pc", bus.exc_pc_o, 32'h0);
    model_clear();
    #1 rst = 1'b1;
    steps(6);

    for (int i = 0; i < 1500; i++) begin
      rand_in();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
